// File: rtl/mips150_uart_mmio_pkg.sv
// Register map, status/irq bit positions and FSM states
// shared by the MIPS150 UART MMIO block.
package mips150_uart_mmio_pkg;

    localparam logic [1:0] UART_STATUS = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_TXDATA = 2'd2;
    localparam logic [1:0] UART_COUNT  = 2'd3;

    localparam int ST_TX_READY     = 0;
    localparam int ST_RX_VALID     = 1;
    localparam int ST_RX_OVERRUN   = 2;
    localparam int ST_RX_FRAME_ERR = 3;
    localparam int ST_TX_BUSY      = 4;

    localparam int IE_RX_VALID = 0;
    localparam int IE_TX_EMPTY = 1;
    localparam int IE_ERR      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/mips150_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; a push on a full FIFO
// is accepted only when a pop happens in the same cycle.
module mips150_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mips150_uart_mmio.sv
// Memory-mapped UART with RX/TX FIFOs and sticky error flags.
// Optional IRQ_EN register and irq output under MIPS150_UART_IRQ_EN.
module mips150_uart_mmio
    import mips150_uart_mmio_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FPGA_SERIAL_RX,
    output logic              FPGA_SERIAL_TX,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              re,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);
    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam int FW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
    localparam logic [CW-1:0] BIT_MID = CW'(CPB / 2);

    logic [1:0] widx;
    logic sel_status, sel_rx, sel_tx, sel_cnt;
    assign widx       = addr[3:2];
    assign sel_status = widx == UART_STATUS;
    assign sel_rx     = widx == UART_RXDATA;
    assign sel_tx     = widx == UART_TXDATA;
    assign sel_cnt    = widx == UART_COUNT;

    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    rx_dout, tx_dout;
    logic [FW-1:0] rx_count, tx_count;

    assign rx_pop  = re && sel_rx && !rx_empty;
    assign tx_push = we && sel_tx;

    uart_state_t   rx_state, rx_state_d;
    logic [CW-1:0] rx_ctr, rx_ctr_d;
    logic [2:0]    rx_idx, rx_idx_d;
    logic [7:0]    rx_shift, rx_shift_d;

    mips150_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push), .din(rx_shift),
        .pop(rx_pop), .dout(rx_dout),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    mips150_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(tx_push), .din(wdata[7:0]),
        .pop(tx_pop), .dout(tx_dout),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // bit 1 is the synchronised line, bit 2 its previous value
    logic [2:0] rx_sync;
    logic       rx_line, rx_fall;
    assign rx_line = rx_sync[1];
    assign rx_fall = rx_sync[2] & ~rx_sync[1];

    logic set_ov, set_fe, rx_ov, rx_fe;

    always_comb begin
        rx_state_d = rx_state;
        rx_ctr_d   = rx_ctr + CW'(1);
        rx_idx_d   = rx_idx;
        rx_shift_d = rx_shift;
        rx_push    = 1'b0;
        set_ov     = 1'b0;
        set_fe     = 1'b0;
        unique case (rx_state)
            IDLE: begin
                rx_ctr_d = '0;
                if (rx_fall) rx_state_d = START;
            end
            START: if (rx_ctr == BIT_MID) begin
                rx_ctr_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_line ? IDLE : DATA;
            end
            DATA: if (rx_ctr == BIT_END) begin
                rx_ctr_d   = '0;
                rx_shift_d = {rx_line, rx_shift[7:1]};
                rx_idx_d   = rx_idx + 3'd1;
                if (rx_idx == 3'd7) rx_state_d = STOP;
            end
            STOP: if (rx_ctr == BIT_END) begin
                rx_ctr_d   = '0;
                rx_state_d = IDLE;
                if (!rx_line)    set_fe  = 1'b1;
                else if (rx_full) set_ov = 1'b1;
                else             rx_push = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync  <= 3'b111;
            rx_state <= IDLE;
            rx_ctr   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[1:0], FPGA_SERIAL_RX};
            rx_state <= rx_state_d;
            rx_ctr   <= rx_ctr_d;
            rx_idx   <= rx_idx_d;
            rx_shift <= rx_shift_d;
        end
    end

    uart_state_t   tx_state, tx_state_d;
    logic [CW-1:0] tx_ctr, tx_ctr_d;
    logic [2:0]    tx_idx, tx_idx_d;
    logic [7:0]    tx_byte, tx_byte_d;
    logic          tx_line_d;

    always_comb begin
        tx_state_d = tx_state;
        tx_ctr_d   = tx_ctr + CW'(1);
        tx_idx_d   = tx_idx;
        tx_byte_d  = tx_byte;
        tx_pop     = 1'b0;
        unique case (tx_state)
            IDLE: begin
                tx_ctr_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_byte_d  = tx_dout;
                    tx_state_d = START;
                end
            end
            START: if (tx_ctr == BIT_END) begin
                tx_ctr_d   = '0;
                tx_idx_d   = '0;
                tx_state_d = DATA;
            end
            DATA: if (tx_ctr == BIT_END) begin
                tx_ctr_d = '0;
                tx_idx_d = tx_idx + 3'd1;
                if (tx_idx == 3'd7) tx_state_d = STOP;
            end
            STOP: if (tx_ctr == BIT_END) begin
                tx_ctr_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_byte_d  = tx_dout;
                    tx_state_d = START;
                end else begin
                    tx_state_d = IDLE;
                end
            end
            default: ;
        endcase
        // line is a registered decode of the next state
        tx_line_d = 1'b1;
        if (tx_state_d == START)     tx_line_d = 1'b0;
        else if (tx_state_d == DATA) tx_line_d = tx_byte_d[tx_idx_d];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state       <= IDLE;
            tx_ctr         <= '0;
            tx_idx         <= '0;
            tx_byte        <= '0;
            FPGA_SERIAL_TX <= 1'b1;
        end else begin
            tx_state       <= tx_state_d;
            tx_ctr         <= tx_ctr_d;
            tx_idx         <= tx_idx_d;
            tx_byte        <= tx_byte_d;
            FPGA_SERIAL_TX <= tx_line_d;
        end
    end

    // a new error in the same cycle as its clear wins
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_ov <= 1'b0;
            rx_fe <= 1'b0;
        end else begin
            if (set_ov) rx_ov <= 1'b1;
            else if (we && sel_status && wdata[ST_RX_OVERRUN]) rx_ov <= 1'b0;
            if (set_fe) rx_fe <= 1'b1;
            else if (we && sel_status && wdata[ST_RX_FRAME_ERR]) rx_fe <= 1'b0;
        end
    end

    logic [4:0]  status;
    logic [31:0] rd_d;

    always_comb begin
        status                  = '0;
        status[ST_TX_READY]     = !tx_full;
        status[ST_RX_VALID]     = !rx_empty;
        status[ST_RX_OVERRUN]   = rx_ov;
        status[ST_RX_FRAME_ERR] = rx_fe;
        status[ST_TX_BUSY]      = (tx_state != IDLE) || !tx_empty;
    end

    always_comb begin
        rd_d = '0;
        unique case (1'b1)
            sel_status: rd_d = {27'b0, status};
            sel_rx:     rd_d = {24'b0, rx_empty ? 8'h00 : rx_dout};
            sel_cnt:    rd_d = {16'b0, 8'(tx_count), 8'(rx_count)};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= rd_d;
    end

`ifdef MIPS150_UART_IRQ_EN
    logic [2:0] irq_en;
    logic [2:0] irq_src;

    always_comb begin
        irq_src              = '0;
        irq_src[IE_RX_VALID] = !rx_empty;
        irq_src[IE_TX_EMPTY] = tx_empty;
        irq_src[IE_ERR]      = rx_ov | rx_fe;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (we && sel_cnt) irq_en <= wdata[2:0];
            irq <= |(irq_en & irq_src);
        end
    end
`else
    assign irq = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{addr, wdata};

endmodule
